// File: rtl/lock_eval_pkg.sv
// Shared types, defaults and the reference-sum helper for the lock key evaluator.
package lock_eval_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int KEY_W_DEF  = 64;

  // Widest operand the golden helper accepts; callers zero-extend into it.
  localparam int SUM_MAX_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_APPLY,
    ST_CHECK,
    ST_DONE
  } eval_state_e;

  // Exact sum with carry-out, so nothing is lost for any operand width up to SUM_MAX_W.
  function automatic logic [SUM_MAX_W:0] golden_sum(input logic [SUM_MAX_W-1:0] a,
                                                    input logic [SUM_MAX_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/locked_adder_key_eval_ctrl_if.sv
// Vector-memory and locked-adder bus seen by the key evaluator.
// master = evaluator side, slave = memory/adder side.
interface locked_adder_key_eval_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int KEY_W  = 64,
  parameter int ADDR_W = 14
);
  logic              vec_rd;
  logic [ADDR_W-1:0] vec_addr;
  logic [DATA_W-1:0] vec_a;
  logic [DATA_W-1:0] vec_b;
  logic [DATA_W-1:0] dut_a;
  logic [DATA_W-1:0] dut_b;
  logic [KEY_W-1:0]  dut_key;
  logic [DATA_W:0]   dut_result;

  modport master (
    output vec_rd, vec_addr, dut_a, dut_b, dut_key,
    input  vec_a, vec_b, dut_result
  );

  modport slave (
    input  vec_rd, vec_addr, dut_a, dut_b, dut_key,
    output vec_a, vec_b, dut_result
  );
endinterface

// File: rtl/lock_err_accum.sv
// Mismatch statistics for one key run: saturating error count, OR-mask of
// differing result bits, and the index of the first failing vector.
module lock_err_accum #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 14
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [DATA_W:0]   result_i,
  input  logic [DATA_W:0]   golden_i,
  input  logic [ADDR_W-1:0] idx_i,
  output logic [CNT_W-1:0]  err_count_o,
  output logic [DATA_W:0]   err_mask_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic              first_err_vld_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W:0] diff;

  assign diff = result_i ^ golden_i;

  // Clear on run start; otherwise fold in one compared vector per enabled cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count_o      <= '0;
      err_mask_o       <= '0;
      first_err_addr_o <= '0;
      first_err_vld_o  <= 1'b0;
    end else if (clear_i) begin
      err_count_o      <= '0;
      err_mask_o       <= '0;
      first_err_addr_o <= '0;
      first_err_vld_o  <= 1'b0;
    end else if (enable_i && (diff != '0)) begin
      if (err_count_o != CNT_MAX) begin
        err_count_o <= err_count_o + CNT_W'(1);
      end
      err_mask_o <= err_mask_o | diff;
      if (!first_err_vld_o) begin
        first_err_vld_o  <= 1'b1;
        first_err_addr_o <= idx_i;
      end
    end
  end

endmodule

// File: rtl/locked_adder_key_eval_ctrl.sv
// Key-sweep sequencer: latches a candidate key, streams N operand pairs from
// the vector memory through the locked adder and checks every result.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start_i; results and key held
// ST_FETCH | read strobe for vector idx is out
// ST_APPLY | memory data valid; registered onto the adder operands
// ST_CHECK | adder output settled; compared against the exact sum
// ST_DONE  | one-cycle completion pulse
module locked_adder_key_eval_ctrl
  import lock_eval_pkg::*;
#(
  parameter int N_VECTORS = 10000,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int KEY_W     = KEY_W_DEF,
  parameter int ADDR_W    = 14,
  parameter int CNT_W     = $clog2(N_VECTORS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [KEY_W-1:0]  key_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  err_count_o,
  output logic [DATA_W:0]   err_mask_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic              first_err_vld_o,
  locked_adder_key_eval_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_VECTORS - 1);

  eval_state_e       state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W:0]   golden;
  logic              run_start;
  logic              check_en;

  assign bus.vec_addr = idx;
  assign run_start    = (state == ST_IDLE) && start_i;
  assign check_en     = (state == ST_CHECK);
  assign golden       = (DATA_W + 1)'(golden_sum(SUM_MAX_W'(bus.dut_a), SUM_MAX_W'(bus.dut_b)));

  // Sequencer; abort wins over every transition outside IDLE, including CHECK->DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      idx         <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      bus.vec_rd  <= 1'b0;
      bus.dut_a   <= '0;
      bus.dut_b   <= '0;
      bus.dut_key <= '0;
    end else begin
      done_o     <= 1'b0;
      bus.vec_rd <= 1'b0;
      if ((state != ST_IDLE) && abort_i) begin
        state  <= ST_IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              bus.dut_key <= key_i;
              idx         <= '0;
              busy_o      <= 1'b1;
              bus.vec_rd  <= 1'b1;
              state       <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            state <= ST_APPLY;
          end
          ST_APPLY: begin
            bus.dut_a <= bus.vec_a;
            bus.dut_b <= bus.vec_b;
            state     <= ST_CHECK;
          end
          ST_CHECK: begin
            if (idx == LAST_IDX) begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= ST_DONE;
            end else begin
              idx        <= idx + ADDR_W'(1);
              bus.vec_rd <= 1'b1;
              state      <= ST_FETCH;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  lock_err_accum #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_err_accum (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clear_i          (run_start),
    .enable_i         (check_en),
    .result_i         (bus.dut_result),
    .golden_i         (golden),
    .idx_i            (idx),
    .err_count_o      (err_count_o),
    .err_mask_o       (err_mask_o),
    .first_err_addr_o (first_err_addr_o),
    .first_err_vld_o  (first_err_vld_o)
  );

endmodule

// File: tb/tb_locked_adder_key_eval_ctrl.sv
// Directed bench for the key evaluator: a 4-entry vector memory, a behavioral
// adder stub with selectable fault injection, and a second instance with a
// 2-bit error counter to exercise saturation.
module tb_locked_adder_key_eval_ctrl;

  localparam logic [63:0] KEY_OK  = 64'h397647A602B128D2;
  localparam logic [63:0] KEY_BAD = 64'h397647A602B128C2;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic        abort_i;
  logic [63:0] key_i;
  logic [1:0]  stub_mode;

  logic        busy_o, done_o, first_err_vld_o;
  logic [2:0]  err_count_o;
  logic [32:0] err_mask_o;
  logic [13:0] first_err_addr_o;

  logic        s_busy, s_done, s_vld;
  logic [1:0]  s_count;
  logic [32:0] s_mask;
  logic [13:0] s_addr;

  logic [31:0] mem_a [4];
  logic [31:0] mem_b [4];

  int n_checks;
  int n_errors;
  int lat;

  locked_adder_key_eval_ctrl_if #(.DATA_W(32), .KEY_W(64), .ADDR_W(14)) bus_m ();
  locked_adder_key_eval_ctrl_if #(.DATA_W(32), .KEY_W(64), .ADDR_W(14)) bus_s ();

  locked_adder_key_eval_ctrl #(
    .N_VECTORS(4), .DATA_W(32), .KEY_W(64), .ADDR_W(14)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i), .key_i(key_i),
    .busy_o(busy_o), .done_o(done_o), .err_count_o(err_count_o), .err_mask_o(err_mask_o),
    .first_err_addr_o(first_err_addr_o), .first_err_vld_o(first_err_vld_o), .bus(bus_m)
  );

  locked_adder_key_eval_ctrl #(
    .N_VECTORS(4), .DATA_W(32), .KEY_W(64), .ADDR_W(14), .CNT_W(2)
  ) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i), .key_i(key_i),
    .busy_o(s_busy), .done_o(s_done), .err_count_o(s_count), .err_mask_o(s_mask),
    .first_err_addr_o(s_addr), .first_err_vld_o(s_vld), .bus(bus_s)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [32:0] adder_stub(input logic [1:0] m, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [32:0] r;
    r = {1'b0, a} + {1'b0, b};
    if (m == 2'd1 && a == 32'd0 && b == 32'd0) r[0] = ~r[0];
    if (m == 2'd2) r[32] = ~r[32];
    return r;
  endfunction

  always @(posedge clk_i) begin
    if (bus_m.vec_rd) begin
      bus_m.vec_a <= mem_a[bus_m.vec_addr[1:0]];
      bus_m.vec_b <= mem_b[bus_m.vec_addr[1:0]];
    end
    if (bus_s.vec_rd) begin
      bus_s.vec_a <= mem_a[bus_s.vec_addr[1:0]];
      bus_s.vec_b <= mem_b[bus_s.vec_addr[1:0]];
    end
  end

  always_comb bus_m.dut_result = adder_stub(stub_mode, bus_m.dut_a, bus_m.dut_b);
  always_comb bus_s.dut_result = adder_stub(stub_mode, bus_s.dut_a, bus_s.dut_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start presented for one edge; key_i is scrambled afterwards to show it is not re-sampled.
  task automatic start_run(input logic [63:0] k);
    @(negedge clk_i);
    start_i = 1'b1;
    key_i   = k;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    key_i   = ~k;
  endtask

  // Counts cycles after the accepting edge until done_o; optional start pokes while busy.
  task automatic wait_done(input bit poke, output int cycles);
    bit found;
    cycles = 0;
    found  = 1'b0;
    for (int i = 1; i <= 60 && !found; i++) begin
      @(negedge clk_i);
      if (i == 1) begin
        check("busy_after_start", 64'(busy_o), 64'd1);
        check("rd_first_cycle", 64'(bus_m.vec_rd), 64'd1);
        check("addr_first_cycle", 64'(bus_m.vec_addr), 64'd0);
      end
      if (done_o) begin
        cycles = i;
        found  = 1'b1;
        check("busy_at_done", 64'(busy_o), 64'd0);
      end
      start_i = poke && (i == 3 || i == 7);
    end
    start_i = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_ni    = 1'b0;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    key_i     = '0;
    stub_mode = 2'd0;
    mem_a[0] = 32'h0000_0001; mem_b[0] = 32'h0000_0002;
    mem_a[1] = 32'hFFFF_FFFF; mem_b[1] = 32'h0000_0001;
    mem_a[2] = 32'h0000_0000; mem_b[2] = 32'h0000_0000;
    mem_a[3] = 32'h8000_0000; mem_b[3] = 32'h8000_0000;

    repeat (2) @(negedge clk_i);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_rd", 64'(bus_m.vec_rd), 64'd0);
    check("rst_key", bus_m.dut_key, 64'd0);
    check("rst_count", 64'(err_count_o), 64'd0);
    check("rst_mask", 64'(err_mask_o), 64'd0);
    check("rst_vld", 64'(first_err_vld_o), 64'd0);
    rst_ni = 1'b1;

    // Correct key, no faults.
    stub_mode = 2'd0;
    start_run(KEY_OK);
    wait_done(1'b0, lat);
    check("ok_latency", 64'(lat), 64'd13);
    check("ok_count", 64'(err_count_o), 64'd0);
    check("ok_mask", 64'(err_mask_o), 64'd0);
    check("ok_vld", 64'(first_err_vld_o), 64'd0);
    check("ok_key_held", bus_m.dut_key, KEY_OK);
    check("ok_last_a", 64'(bus_m.dut_a), 64'h8000_0000);
    check("ok_last_b", 64'(bus_m.dut_b), 64'h8000_0000);

    // Wrong key, bit 0 flipped on vector 2; started in the cycle right after done.
    stub_mode = 2'd1;
    start_run(KEY_BAD);
    wait_done(1'b0, lat);
    check("bad_latency", 64'(lat), 64'd13);
    check("bad_count", 64'(err_count_o), 64'd1);
    check("bad_mask", 64'(err_mask_o), 64'h1);
    check("bad_addr", 64'(first_err_addr_o), 64'd2);
    check("bad_vld", 64'(first_err_vld_o), 64'd1);
    check("bad_key_held", bus_m.dut_key, KEY_BAD);

    // Bit 32 inverted on every vector; start pokes while busy must not move done.
    stub_mode = 2'd2;
    start_run(KEY_BAD);
    wait_done(1'b1, lat);
    check("msb_latency", 64'(lat), 64'd13);
    check("msb_count", 64'(err_count_o), 64'd4);
    check("msb_mask", 64'(err_mask_o), 64'h1_0000_0000);
    check("msb_addr", 64'(first_err_addr_o), 64'd0);
    check("sat_count", 64'(s_count), 64'd3);
    check("sat_mask", 64'(s_mask), 64'h1_0000_0000);
    check("sat_vld", 64'(s_vld), 64'd1);

    // Abort during the second CHECK.
    start_run(KEY_OK);
    for (int i = 1; i <= 6; i++) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    check("abort_count", 64'(err_count_o), 64'd2);
    check("abort_addr", 64'(first_err_addr_o), 64'd0);
    check("abort_mask", 64'(err_mask_o), 64'h1_0000_0000);
    begin
      int n_done;
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_i);
        if (done_o) n_done++;
      end
      check("abort_no_done", 64'(n_done), 64'd0);
      check("abort_idle_rd", 64'(bus_m.vec_rd), 64'd0);
    end
    start_run(KEY_OK);
    wait_done(1'b0, lat);
    check("rerun_latency", 64'(lat), 64'd13);
    check("rerun_count", 64'(err_count_o), 64'd4);
    check("rerun_sat", 64'(s_count), 64'd3);

    // Asynchronous reset in the first APPLY cycle.
    stub_mode = 2'd0;
    start_run(KEY_BAD);
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_rd", 64'(bus_m.vec_rd), 64'd0);
    check("arst_key", bus_m.dut_key, 64'd0);
    check("arst_a", 64'(bus_m.dut_a), 64'd0);
    check("arst_b", 64'(bus_m.dut_b), 64'd0);
    check("arst_sat_count", 64'(s_count), 64'd0);
    @(negedge clk_i);
    check("arst_done", 64'(done_o), 64'd0);
    rst_ni = 1'b1;
    start_run(KEY_OK);
    wait_done(1'b0, lat);
    check("post_rst_latency", 64'(lat), 64'd13);
    check("post_rst_count", 64'(err_count_o), 64'd0);
    check("post_rst_key", bus_m.dut_key, KEY_OK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
